// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer.
//   ALU_WIDTH  : default operand/result width
//   OP_*       : 3-bit ALU opcodes
//   seq_state_t: sequencer FSM states
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the ALU operand/result interface.
// Takes a command (a, b, sel, chain) over a valid/ready channel, drives
// registered operands into a combinational ALU, waits SETTLE_CYCLES, samples
// result/carry/zero and returns them over a valid/ready response channel.
// The last sampled result is kept in an accumulator that a chained command
// uses as operand a.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_a/cmd_b/cmd_sel/cmd_chain command payload
//   alu_a/alu_b/alu_sel           registered operands to the ALU
//   alu_result/carry/zero         ALU outputs, sampled at end of settle window
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/carry/zero         sampled response payload
//   op_count                      accepted responses, wraps
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_sel,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  // Settle counter is loaded with SETTLE_CYCLES-1 so that the sample lands
  // exactly SETTLE_CYCLES edges after acceptance.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_t       state, state_nxt;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] acc;

  // Handshake qualifiers; cmd_ready/rsp_valid come from registered state.
  logic cmd_fire, rsp_fire, sample_now;

  assign cmd_fire   = (state == IDLE) && cmd_valid;
  assign rsp_fire   = (state == RESP) && rsp_valid && rsp_ready;
  assign sample_now = (state == DRIVE) && (settle_cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = DRIVE;
      end
      DRIVE: if (settle_cnt == 4'd0) state_nxt = RESP;
      RESP:  if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= 3'd0;
      acc        <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nxt;

      // Operands only change on acceptance; they persist through IDLE/RESP.
      if (cmd_fire) begin
        alu_a      <= cmd_chain ? acc : cmd_a;
        alu_b      <= cmd_b;
        alu_sel    <= cmd_sel;
        settle_cnt <= SETTLE_LOAD;
      end else if (state == DRIVE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end

      if (sample_now) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
        acc        <= alu_result;
        rsp_valid  <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (settle 1 / 2-bit counter and
// settle 4 / 8-bit counter), each wired to a behavioural ALU.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, cmd_valid, cmd_ready, cmd_chain, alu_carry, alu_zero;
  logic [1:0]      rsp_valid, rsp_ready, rsp_carry, rsp_zero;
  logic [1:0][3:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
  logic [1:0][2:0] cmd_sel, alu_sel;
  logic [1:0][4:0] alu_raw;
  logic [1:0]      opc0;
  logic [7:0]      opc1;

  // {carry, result} of the ALU; SUB carry is the borrow out.
  function automatic logic [4:0] ref_alu(input logic [3:0] a, b, input logic [2:0] sel);
    case (sel)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NOT:  return {1'b0, ~a};
      OP_SHL:  return {a, 1'b0};
      default: return {a[0], 1'b0, a[3:1]};
    endcase
  endfunction

  always_comb begin
    alu_raw = '0;
    for (int d = 0; d < 2; d++) begin
      alu_raw[d]    = ref_alu(alu_a[d], alu_b[d], alu_sel[d]);
      alu_result[d] = alu_raw[d][3:0];
      alu_carry[d]  = alu_raw[d][4];
      alu_zero[d]   = (alu_raw[d][3:0] == 4'd0);
    end
  end

  alu_cmd_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1), .CNT_W(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_sel(cmd_sel[0]), .cmd_chain(cmd_chain[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]),
    .alu_result(alu_result[0]), .alu_carry(alu_carry[0]), .alu_zero(alu_zero[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_carry(rsp_carry[0]), .rsp_zero(rsp_zero[0]), .op_count(opc0));

  alu_cmd_sequencer #(.WIDTH(4), .SETTLE_CYCLES(4), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_sel(cmd_sel[1]), .cmd_chain(cmd_chain[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]),
    .alu_result(alu_result[1]), .alu_carry(alu_carry[1]), .alu_zero(alu_zero[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_carry(rsp_carry[1]), .rsp_zero(rsp_zero[1]), .op_count(opc1));

  int total = 0, bad = 0;
  int stv[2]  = '{1, 4};
  int modv[2] = '{4, 256};
  int ocnt[2];
  logic [3:0] acc[2], exp_a[2], got_a[2], got_r[2];
  logic       got_c[2], got_z[2];
  logic [4:0] pend[2];

  function automatic int get_opc(input int d);
    return (d == 0) ? int'(opc0) : int'(opc1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    @(negedge clk); @(negedge clk);
    rst[d] = 1'b0;
    acc[d] = 4'd0; ocnt[d] = 0;
    chk("rst_cmd_ready", int'(cmd_ready[d]), 1);
    chk("rst_rsp_valid", int'(rsp_valid[d]), 0);
    chk("rst_alu", int'({alu_a[d], alu_b[d], alu_sel[d]}), 0);
    chk("rst_rsp", int'({rsp_result[d], rsp_carry[d], rsp_zero[d]}), 0);
    chk("rst_opc", get_opc(d), 0);
  endtask

  // Present a command (entered at a negedge), wait for acceptance, check ALU pins.
  task automatic issue(input int d, input logic [3:0] a, b, input logic [2:0] sel, input logic ch);
    int n = 0;
    cmd_a[d] = a; cmd_b[d] = b; cmd_sel[d] = sel; cmd_chain[d] = ch; cmd_valid[d] = 1'b1;
    while (!cmd_ready[d] && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", int'(cmd_ready[d]), 1);
    @(posedge clk); @(negedge clk);
    cmd_valid[d] = 1'b0;
    exp_a[d] = ch ? acc[d] : a;
    pend[d]  = ref_alu(exp_a[d], b, sel);
    got_a[d] = alu_a[d];
    chk("drive_alu_a", int'(alu_a[d]), int'(exp_a[d]));
    chk("drive_alu_b", int'(alu_b[d]), int'(b));
    chk("drive_alu_sel", int'(alu_sel[d]), int'(sel));
    chk("drive_cmd_ready", int'(cmd_ready[d]), 0);
  endtask

  task automatic await_rsp(input int d);
    int lat = 0;
    while (!rsp_valid[d] && lat < 40) begin @(negedge clk); lat++; end
    chk("latency", lat, stv[d]);
    chk("rsp_result", int'(rsp_result[d]), int'(pend[d][3:0]));
    chk("rsp_carry", int'(rsp_carry[d]), int'(pend[d][4]));
    chk("rsp_zero", int'(rsp_zero[d]), int'(pend[d][3:0] == 4'd0));
    got_r[d] = rsp_result[d]; got_c[d] = rsp_carry[d]; got_z[d] = rsp_zero[d];
    acc[d] = pend[d][3:0];
  endtask

  task automatic stall(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", int'(rsp_valid[d]), 1);
      chk("stall_rsp", int'({rsp_result[d], rsp_carry[d], rsp_zero[d]}),
          int'({got_r[d], got_c[d], got_z[d]}));
      chk("stall_cmd_ready", int'(cmd_ready[d]), 0);
      chk("stall_alu_a", int'(alu_a[d]), int'(exp_a[d]));
    end
  endtask

  task automatic release_rsp(input int d);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    ocnt[d] = (ocnt[d] + 1) % modv[d];
    chk("hs_opc", get_opc(d), ocnt[d]);
    chk("hs_rsp_valid", int'(rsp_valid[d]), 0);
    chk("hs_cmd_ready", int'(cmd_ready[d]), 1);
  endtask

  task automatic do_op(input int d, input logic [3:0] a, b, input logic [2:0] sel,
                       input logic ch, input int dly);
    issue(d, a, b, sel, ch);
    await_rsp(d);
    if (dly > 0) stall(d, dly);
    release_rsp(d);
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic [2:0] sel;
    logic       ch;
    logic [3:0] xa, xr;
    logic       xc, xz;
    int         xcnt;
  } vec_t;

  vec_t tv[10];

  initial begin
    rst = 2'b11; cmd_valid = '0; cmd_chain = '0; rsp_ready = '0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0;
    ocnt = '{0, 0};
    acc = '{4'd0, 4'd0};

    tv[0] = '{4'h5, 4'h3, OP_ADD, 1'b0, 4'h5, 4'h8, 1'b0, 1'b0, 1};
    tv[1] = '{4'hC, 4'h4, OP_ADD, 1'b0, 4'hC, 4'h0, 1'b1, 1'b1, 2};
    tv[2] = '{4'h5, 4'h3, OP_ADD, 1'b0, 4'h5, 4'h8, 1'b0, 1'b0, 3};
    tv[3] = '{4'hF, 4'h1, OP_ADD, 1'b1, 4'h8, 4'h9, 1'b0, 1'b0, 0};
    tv[4] = '{4'h3, 4'h5, OP_SUB, 1'b0, 4'h3, 4'hE, 1'b1, 1'b0, 1};
    tv[5] = '{4'hA, 4'hA, OP_XOR, 1'b0, 4'hA, 4'h0, 1'b0, 1'b1, 2};
    tv[6] = '{4'h9, 4'h0, OP_SHL, 1'b0, 4'h9, 4'h2, 1'b1, 1'b0, 3};
    tv[7] = '{4'h0, 4'h0, OP_SHR, 1'b1, 4'h2, 4'h1, 1'b0, 1'b0, 0};
    tv[8] = '{4'h0, 4'h0, OP_NOT, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1};
    tv[9] = '{4'hC, 4'hA, OP_AND, 1'b0, 4'hC, 4'h8, 1'b0, 1'b0, 2};

    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // Directed vectors incl. carry/zero, chaining and 2-bit counter wrap.
    for (int i = 0; i < 10; i++) begin
      do_op(0, tv[i].a, tv[i].b, tv[i].sel, tv[i].ch, 0);
      chk("tv_alu_a", int'(got_a[0]), int'(tv[i].xa));
      chk("tv_result", int'(got_r[0]), int'(tv[i].xr));
      chk("tv_carry", int'(got_c[0]), int'(tv[i].xc));
      chk("tv_zero", int'(got_z[0]), int'(tv[i].xz));
      chk("tv_opc", get_opc(0), tv[i].xcnt);
    end

    // rsp_ready with nothing pending must not count.
    rsp_ready[0] = 1'b1;
    repeat (2) @(negedge clk);
    rsp_ready[0] = 1'b0;
    chk("idle_ready_opc", get_opc(0), 2);
    chk("idle_ready_valid", int'(rsp_valid[0]), 0);

    // Backpressure with a second command waiting.
    issue(0, 4'h1, 4'h2, OP_ADD, 1'b0);
    await_rsp(0);
    cmd_a[0] = 4'h7; cmd_b[0] = 4'h1; cmd_sel[0] = OP_OR; cmd_chain[0] = 1'b0;
    cmd_valid[0] = 1'b1;
    stall(0, 5);
    release_rsp(0);
    chk("bp_opc_step", get_opc(0), 3);
    issue(0, 4'h7, 4'h1, OP_OR, 1'b0);
    await_rsp(0);
    chk("bp_second_result", int'(got_r[0]), 7);
    release_rsp(0);

    // Reset during the second DRIVE cycle discards the op.
    issue(1, 4'h6, 4'h6, OP_ADD, 1'b0);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    acc[1] = 4'd0; ocnt[1] = 0;
    chk("midrst_cmd_ready", int'(cmd_ready[1]), 1);
    chk("midrst_rsp_valid", int'(rsp_valid[1]), 0);
    chk("midrst_alu", int'({alu_a[1], alu_b[1], alu_sel[1]}), 0);
    chk("midrst_opc", get_opc(1), 0);
    repeat (5) @(negedge clk);
    chk("midrst_no_rsp", int'(rsp_valid[1]), 0);

    // Chain as the first command after reset uses a = 0.
    do_op(1, 4'hF, 4'h3, OP_ADD, 1'b1, 0);
    chk("chain_after_rst_a", int'(got_a[1]), 0);
    chk("chain_after_rst_r", int'(got_r[1]), 3);

    // Random ops with random backpressure against the model.
    for (int i = 0; i < 60; i++) begin
      do_op(i % 2, 4'($urandom_range(15)), 4'($urandom_range(15)),
            3'($urandom_range(7)), 1'($urandom_range(1)), int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
